// File: rtl/csd2bin.sv
// Multi-cycle CSD-to-two's-complement decoder: Horner accumulation, MSB digit first, DPC digits/clock.
// Optional input checking (illegal code 10, adjacent nonzero digits) is enabled by defining CSD_CHECK_EN.
module csd2bin #(
    parameter int W   = 4,
    parameter int DPC = 1
) (
    input  logic           clk,
    input  logic           arst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W:0]     x,
    output logic           err
);

    localparam int N  = W / DPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state;
    logic [2*W-1:0]     sr;
    logic signed [W:0]  acc;
    logic [CW-1:0]      cnt;
    logic signed [W:0]  grp_sum;
    logic signed [W:0]  acc_next;
    logic signed [W:0]  wt;
    logic [1:0]         code;
    logic               last_cyc;

`ifdef CSD_CHECK_EN
    logic sticky;
    logic prev_nz;
    logic chk_flag;
    logic last_nz;
    logic nz_run;
`endif

    assign last_cyc = (cnt == CW'(N - 1));

    // Top DPC digits of the shift register, weighted MSB-first within the group.
    always_comb begin
        grp_sum = '0;
        wt      = '0;
        code    = '0;
`ifdef CSD_CHECK_EN
        chk_flag = 1'b0;
        nz_run   = prev_nz;
`endif
        for (int unsigned j = 0; j < DPC; j++) begin
            code = sr[2*W-1-2*j -: 2];
            wt   = '0;
            wt[DPC-1-j] = 1'b1;
            if (code == 2'b01)
                grp_sum = grp_sum + wt;
            else if (code == 2'b11)
                grp_sum = grp_sum - wt;
`ifdef CSD_CHECK_EN
            if (code == 2'b10)
                chk_flag = 1'b1;
            if (code[0] && nz_run)
                chk_flag = 1'b1;
            nz_run = code[0];
`endif
        end
`ifdef CSD_CHECK_EN
        last_nz = nz_run;
`endif
        acc_next = (acc <<< DPC) + grp_sum;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            x         <= '0;
            sr        <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sr       <= y;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    sr  <= sr << (2 * DPC);
                    cnt <= cnt + 1'b1;
                    if (last_cyc) begin
                        x         <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CSD_CHECK_EN
    // prev_nz carries the last digit of a group so adjacency spanning groups is caught.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sticky  <= 1'b0;
            prev_nz <= 1'b0;
            err     <= 1'b0;
        end else if (state == IDLE && in_valid && in_ready) begin
            sticky  <= 1'b0;
            prev_nz <= 1'b0;
        end else if (state == CONV) begin
            sticky  <= sticky | chk_flag;
            prev_nz <= last_nz;
            if (last_cyc)
                err <= sticky | chk_flag;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_csd2bin.sv
// Self-checking bench for csd2bin: W=4/DPC=1 and W=8/DPC=2 instances against an arithmetic CSD model.
module tb_csd2bin;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        arst;
    logic        ordy;
    logic        iv4, ir4, ov4, er4;
    logic [7:0]  y4;
    logic [4:0]  x4;
    logic        iv8, ir8, ov8, er8;
    logic [15:0] y8;
    logic [8:0]  x8;

    int   checks = 0;
    int   errors = 0;
    bit   cur_sel = 1'b0;

    csd2bin #(.W(4), .DPC(1)) dut4 (
        .clk(clk), .arst(arst), .in_valid(iv4), .in_ready(ir4), .y(y4),
        .out_valid(ov4), .out_ready(ordy), .x(x4), .err(er4)
    );

    csd2bin #(.W(8), .DPC(2)) dut8 (
        .clk(clk), .arst(arst), .in_valid(iv8), .in_ready(ir8), .y(y8),
        .out_valid(ov8), .out_ready(ordy), .x(x8), .err(er8)
    );

    always #5 clk = ~clk;

    function automatic logic get_ir();
        return cur_sel ? ir8 : ir4;
    endfunction
    function automatic logic get_ov();
        return cur_sel ? ov8 : ov4;
    endfunction
    function automatic logic get_er();
        return cur_sel ? er8 : er4;
    endfunction
    function automatic int get_x();
        return cur_sel ? int'($signed(x8)) : int'($signed(x4));
    endfunction

    // Value = sum of digit_i * 2^i; code 10 counts as zero.
    function automatic int csd_val(input logic [15:0] yv, input int w);
        int v = 0;
        for (int i = 0; i < w; i++) begin
            if (yv[2*i +: 2] == 2'b01) v += (1 << i);
            else if (yv[2*i +: 2] == 2'b11) v -= (1 << i);
        end
        return v;
    endfunction

    function automatic logic csd_err(input logic [15:0] yv, input int w);
        logic e = 1'b0;
        logic p = 1'b0;
        logic nz;
        for (int i = w - 1; i >= 0; i--) begin
            if (yv[2*i +: 2] == 2'b10) e = 1'b1;
            nz = (yv[2*i +: 2] == 2'b01) || (yv[2*i +: 2] == 2'b11);
            if (nz && p) e = 1'b1;
            p = nz;
        end
`ifdef CSD_CHECK_EN
        return e;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic drive_word(input bit sel, input logic [15:0] yv);
        if (sel) begin y8 = yv; iv8 = 1'b1; end
        else     begin y4 = yv[7:0]; iv4 = 1'b1; end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!get_ir() && k < 20) begin
            @(posedge clk); #1; k++;
        end
        chk("in_ready_wait", 32'(get_ir()), 32'd1);
    endtask

    task automatic xfer(input bit sel, input logic [15:0] yv, input int hold);
        int   w   = sel ? 8 : 4;
        int   ev  = csd_val(yv, w);
        logic ee  = csd_err(yv, w);
        int   lat = 0;
        cur_sel = sel;
        wait_ready();
        drive_word(sel, yv);
        @(posedge clk); #1;
        chk("ready_low_after_accept", 32'(get_ir()), 32'd0);
        chk("no_early_valid", 32'(get_ov()), 32'd0);
        // keep in_valid high with junk: must be ignored outside IDLE
        drive_word(sel, 16'($urandom));
        while (!get_ov() && lat < N + 4) begin
            @(posedge clk); #1; lat++;
        end
        iv4 = 1'b0; iv8 = 1'b0;
        chk("latency", 32'(lat), 32'(N));
        chk("x", 32'(get_x()), 32'(ev));
        chk("err", 32'(get_er()), 32'(ee));
        chk("ready_low_in_done", 32'(get_ir()), 32'd0);
        if (hold > 0) begin
            ordy = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk("bp_valid_held", 32'(get_ov()), 32'd1);
                chk("bp_x_held", 32'(get_x()), 32'(ev));
                chk("bp_ready_low", 32'(get_ir()), 32'd0);
            end
            ordy = 1'b1;
        end
        @(posedge clk); #1;
        chk("valid_drop", 32'(get_ov()), 32'd0);
        chk("ready_back", 32'(get_ir()), 32'd1);
        chk("x_hold_idle", 32'(get_x()), 32'(ev));
    endtask

    logic [15:0] dir_words [7] = '{16'h0043, 16'h004C, 16'h00C0, 16'h0000, 16'h0005, 16'h0080, 16'h0011};

    initial begin
        int seen;
        arst = 1'b1; ordy = 1'b1;
        iv4 = 1'b0; iv8 = 1'b0; y4 = '0; y8 = '0;
        #1;
        for (int s = 0; s < 2; s++) begin
            cur_sel = bit'(s);
            chk("rst_ready", 32'(get_ir()), 32'd0);
            chk("rst_valid", 32'(get_ov()), 32'd0);
            chk("rst_x", 32'(get_x()), 32'd0);
            chk("rst_err", 32'(get_er()), 32'd0);
        end
        @(posedge clk);
        @(negedge clk) arst = 1'b0;
        @(posedge clk); #1;
        cur_sel = 1'b0;
        chk("ready_rise4", 32'(get_ir()), 32'd1);
        cur_sel = 1'b1;
        chk("ready_rise8", 32'(get_ir()), 32'd1);

        for (int i = 0; i < 7; i++)
            xfer(1'b0, dir_words[i], (i == 4) ? 10 : 0);
        xfer(1'b0, 16'h0001, 10);
        xfer(1'b1, 16'h4003, 0);
        xfer(1'b1, 16'h1104, 2);

        for (int i = 0; i < 40; i++)
            xfer(bit'(i % 2), 16'($urandom), $urandom_range(0, 3));

        // abort a conversion with arst two cycles in, after a nonzero result
        xfer(1'b0, 16'h0011, 0);
        cur_sel = 1'b0;
        drive_word(1'b0, 16'h0041);
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst = 1'b1;
        #1;
        chk("abort_valid", 32'(get_ov()), 32'd0);
        chk("abort_x", 32'(get_x()), 32'd0);
        chk("abort_err", 32'(get_er()), 32'd0);
        chk("abort_ready", 32'(get_ir()), 32'd0);
        @(negedge clk) arst = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready_rise", 32'(get_ir()), 32'd1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (get_ov()) seen = 1;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        xfer(1'b0, 16'h0043, 0);
        xfer(1'b1, 16'h0C1D, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
